// File: rtl/seg_pkg.sv
// Shared types and helpers for the 7-segment scan controllers.
package seg_pkg;

  typedef enum logic {SCAN_BLANK, SCAN_SHOW} scan_state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Width of a counter that must hold 0..n-1 (never narrower than one bit)
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_lz_mask.sv
// Per-digit displayable mask: hides digits above 9 and, optionally, leading zeros.
module seg_lz_mask
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic [4*NUM_DIGITS-1:0] active,
  input  logic                    lz_blank,
  output logic [NUM_DIGITS-1:0]   mask
);

  // Walk from the most significant digit down; once a nonzero digit is seen,
  // every lower digit is significant. Digit 0 is never treated as a leading zero.
  always_comb begin
    logic seen_nz;
    seen_nz = 1'b0;
    mask    = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (active[4*k +: 4] != 4'd0) seen_nz = 1'b1;
      mask[k] = (active[4*k +: 4] <= BCD_MAX) && ((k == 0) || !lz_blank || seen_nz);
    end
  end

endmodule

// File: rtl/seg_scan_controller.sv
// Scans NUM_DIGITS BCD digits onto one shared decoder with blank slots and
// frame-synchronous double buffering so a displayed frame never tears.
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 2500,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    lz_blank,
  output logic                    pending,
  output logic [3:0]              dec_value,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic                    frame_tick
);

  localparam int CNT_W = cnt_width(REFRESH_DIV);
  localparam int IDX_W = cnt_width(NUM_DIGITS);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_t               state, state_next;
  logic [CNT_W-1:0]          cnt;
  logic [IDX_W-1:0]          idx;
  logic [4*NUM_DIGITS-1:0]   active, shadow;
  logic                      lz_q;
  logic [NUM_DIGITS-1:0]     mask;
  logic [3:0]                digit [NUM_DIGITS];
  logic                      slot_wrap, boundary;

  assign slot_wrap = (cnt == SLOT_LAST);
  assign boundary  = slot_wrap && (idx == IDX_LAST);

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    assign digit[g] = active[4*g +: 4];
  end

  seg_lz_mask #(.NUM_DIGITS(NUM_DIGITS)) u_lz_mask (
    .active   (active),
    .lz_blank (lz_q),
    .mask     (mask)
  );

  // Scan state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SCAN_BLANK;
    else       state <= state_next;
  end

  // Blank for the leading cycles of a slot, show until the slot wraps
  always_comb begin
    state_next = state;
    case (state)
      SCAN_BLANK: if (cnt == BLANK_LAST) state_next = SCAN_SHOW;
      SCAN_SHOW:  if (slot_wrap)         state_next = SCAN_BLANK;
    endcase
  end

  // Slot counter and digit index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_wrap) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Double buffer: loads land in shadow; active only changes on a frame boundary,
  // where a coincident load bypasses straight into the new frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      if (load) shadow <= digits_in;
      if (boundary) begin
        if (load)         active <= digits_in;
        else if (pending) active <= shadow;
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // Registered copies of lz_blank and the frame start, keeping outputs Moore-only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lz_q       <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      lz_q       <= lz_blank;
      frame_tick <= boundary;
    end
  end

  // Decoder value is held for the whole slot so it settles during blanking
  always_comb begin
    dec_value = (digit[idx] > BCD_MAX) ? 4'd0 : digit[idx];
  end

  // Anode of the current digit is lit only in SHOW and only if displayable
  always_comb begin
    anode_n = '1;
    if (state == SCAN_SHOW && mask[idx]) anode_n[idx] = 1'b0;
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Randomized and directed bench for seg_scan_controller against a frame-position model.
module tb_seg_scan_controller;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FR = ND * RD;

  logic          clk = 1'b0;
  logic          reset;
  logic          load;
  logic [15:0]   digits_in;
  logic          lz_blank;
  logic          pending;
  logic [3:0]    dec_value;
  logic [ND-1:0] anode_n;
  logic          frame_tick;

  int checks = 0;
  int errors = 0;

  // Reference model: cycles since reset release, displayed/buffered digits
  int       n;
  logic [3:0] m_act [ND];
  logic [3:0] m_sh  [ND];
  bit       m_pend;
  bit       m_lz;
  bit       cur_lz;

  seg_scan_controller #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .digits_in  (digits_in),
    .lz_blank   (lz_blank),
    .pending    (pending),
    .dec_value  (dec_value),
    .anode_n    (anode_n),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, n, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0;
    m_pend = 0;
    m_lz = 0;
    for (int i = 0; i < ND; i++) begin
      m_act[i] = 4'd0;
      m_sh[i]  = 4'd0;
    end
  endtask

  task automatic check_outputs();
    int pos, i, c, msd;
    logic [3:0] d;
    logic [ND-1:0] exp_an;
    bit disp;
    pos = n % FR;
    i   = pos / RD;
    c   = pos % RD;
    msd = -1;
    for (int k = 0; k < ND; k++) if (m_act[k] != 4'd0) msd = k;
    d = m_act[i];
    disp = (d <= 4'd9) && (i == 0 || !m_lz || i <= msd);
    exp_an = '1;
    if (c >= BC && disp) exp_an[i] = 1'b0;
    chk("dec_value", 16'(dec_value), (d > 4'd9) ? 16'd0 : 16'(d));
    chk("anode_n", 16'(anode_n), 16'(exp_an));
    chk("frame_tick", 16'(frame_tick), 16'((n > 0 && pos == 0) ? 1 : 0));
    chk("pending", 16'(pending), 16'(m_pend));
  endtask

  task automatic model_edge(input bit ld, input logic [15:0] d, input bit lzv);
    if (n % FR == FR - 1) begin
      if (ld) begin
        for (int k = 0; k < ND; k++) m_act[k] = d[4*k +: 4];
      end else if (m_pend) begin
        for (int k = 0; k < ND; k++) m_act[k] = m_sh[k];
      end
      m_pend = 0;
    end else if (ld) begin
      m_pend = 1;
    end
    if (ld) for (int k = 0; k < ND; k++) m_sh[k] = d[4*k +: 4];
    m_lz = lzv;
    n++;
  endtask

  // One clock: check current outputs, drive inputs, advance DUT and model
  task automatic cyc(input bit ld, input logic [15:0] d);
    check_outputs();
    load      = ld;
    digits_in = d;
    lz_blank  = cur_lz;
    @(posedge clk);
    model_edge(ld, d, cur_lz);
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b0, 16'h0);
  endtask

  task automatic run_until(input int p);
    for (int i = 0; i < FR && (n % FR) != p; i++) cyc(1'b0, 16'h0);
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] v;
    for (int k = 0; k < ND; k++)
      v[4*k +: 4] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 11));
    return v;
  endfunction

  initial begin
    reset = 1'b1;
    load = 1'b0;
    digits_in = 16'h0;
    lz_blank = 1'b0;
    cur_lz = 1'b0;
    model_reset();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    reset = 1'b0;

    // Basic load and scan
    cyc(1'b1, 16'h1234);
    idle(2 * FR);

    // Leading-zero blanking
    cur_lz = 1'b1;
    cyc(1'b1, 16'h0070);
    idle(2 * FR);
    cyc(1'b1, 16'h0000);
    idle(2 * FR);

    // Non-BCD digit in position 2
    cur_lz = 1'b0;
    cyc(1'b1, 16'h4C21);
    idle(2 * FR);

    // Last load in a frame wins
    run_until(3);
    cyc(1'b1, 16'h1111);
    run_until(10);
    cyc(1'b1, 16'h2222);
    idle(FR + 4);

    // Load exactly on the boundary cycle
    run_until(FR - 1);
    cyc(1'b1, 16'h5678);
    idle(FR);

    // Randomized traffic
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 49) == 0) cur_lz = ~cur_lz;
      if ($urandom_range(0, 19) == 0) cyc(1'b1, rand_digits());
      else                            cyc(1'b0, 16'h0);
    end

    // Reset during idx2 SHOW with a pending load
    cur_lz = 1'b0;
    run_until(2 * RD + 3);
    cyc(1'b1, 16'h9999);
    reset = 1'b1;
    #1;
    chk("reset anode_n", 16'(anode_n), 16'hF);
    chk("reset pending", 16'(pending), 16'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    reset = 1'b0;
    idle(2 * FR);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
